// File: rtl/scc_mem_pkg.sv
// Shared definitions for the unified memory port arbiter.
//   - arb_state_e : arbiter FSM states
//   - DEF_*       : default address/data widths and ack timeout
//   - arb_pick_d  : round-robin pick between fetch and data requesters
package scc_mem_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_GNT_IF = 2'd1,
        ARB_GNT_D  = 2'd2
    } arb_state_e;

    localparam int DEF_ADDR_W  = 32;
    localparam int DEF_DATA_W  = 32;
    localparam int DEF_TIMEOUT = 255;

    // Returns 1 when the data side should be granted. On a tie the side
    // that was not granted last wins; last_d = 0 after reset lets data win
    // the first tie.
    function automatic logic arb_pick_d(input logic if_elig,
                                        input logic d_elig,
                                        input logic last_d);
        logic pick;
        if (if_elig && d_elig) begin
            pick = ~last_d;
        end else begin
            pick = d_elig;
        end
        return pick;
    endfunction

endpackage

// File: rtl/mem_arb_timer.sv
// Acknowledge timeout counter for the memory port arbiter.
//   clk, reset : clock, synchronous active-high reset
//   clear      : load the counter with zero (takes priority)
//   enable     : count one more cycle without acknowledge
//   expired    : registered flag, high while the count equals TIMEOUT
// The counter saturates at TIMEOUT; the arbiter completes the transaction
// in the cycle expired is seen, so the count never wraps.
module mem_arb_timer
    import scc_mem_pkg::*;
#(
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             expired_q;
    logic             expired_d;

    // Next count: clear, saturating increment, or hold.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = {CNT_W{1'b0}};
        end else if (enable && !expired_q) begin
            count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            count_d = count_q;
        end
        expired_d = (count_d == LIMIT);
    end

    // Counter and expiry flag registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q   <= {CNT_W{1'b0}};
            expired_q <= 1'b0;
        end else begin
            count_q   <= count_d;
            expired_q <= expired_d;
        end
    end

    assign expired = expired_q;

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between the instruction-fetch and data requesters.
//   if_req/if_addr -> if_ready/if_rdata          : fetch side (read only)
//   d_req/d_we/d_addr/d_wdata -> d_ready/d_rdata : data side
//   mem_req/mem_we/mem_addr/mem_wdata, mem_ack/mem_rdata : memory port
//   bus_err : pulses with *_ready when the memory did not acknowledge in time
//   busy    : high whenever a grant is in flight
// All outputs are registered. One requester is granted at a time with
// round-robin fairness; completion takes the IDLE state for one cycle so
// there is always an idle bus cycle between transactions.
module mem_port_arbiter
    import scc_mem_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ready,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ready,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              bus_err,
    output logic              busy
);

    arb_state_e        state_q, state_d;
    logic              last_d_q, last_d_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              if_ready_q, if_ready_d;
    logic              d_ready_q, d_ready_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
    logic              bus_err_q, bus_err_d;
    logic              busy_q, busy_d;

    logic              if_elig_s;
    logic              d_elig_s;
    logic              tmr_clear_s;
    logic              tmr_en_s;
    logic              tmr_expired_s;

    mem_arb_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   (tmr_clear_s),
        .enable  (tmr_en_s),
        .expired (tmr_expired_s)
    );

    // A requester whose ready pulse is high this cycle is still dropping its
    // req, so it is not eligible for a new grant yet.
    assign if_elig_s = if_req && !if_ready_q;
    assign d_elig_s  = d_req  && !d_ready_q;

    // Arbiter next-state, grant capture and completion logic.
    always_comb begin
        state_d     = state_q;
        last_d_d    = last_d_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_ready_d  = 1'b0;
        d_ready_d   = 1'b0;
        if_rdata_d  = if_rdata_q;
        d_rdata_d   = d_rdata_q;
        bus_err_d   = 1'b0;
        tmr_clear_s = 1'b0;
        tmr_en_s    = 1'b0;

        case (state_q)
            ARB_IDLE: begin
                if (if_elig_s || d_elig_s) begin
                    tmr_clear_s = 1'b1;
                    mem_req_d   = 1'b1;
                    if (arb_pick_d(if_elig_s, d_elig_s, last_d_q)) begin
                        state_d     = ARB_GNT_D;
                        last_d_d    = 1'b1;
                        mem_we_d    = d_we;
                        mem_addr_d  = d_addr;
                        mem_wdata_d = d_wdata;
                    end else begin
                        state_d     = ARB_GNT_IF;
                        last_d_d    = 1'b0;
                        mem_we_d    = 1'b0;
                        mem_addr_d  = if_addr;
                        mem_wdata_d = {DATA_W{1'b0}};
                    end
                end else begin
                    state_d = ARB_IDLE;
                end
            end
            ARB_GNT_IF, ARB_GNT_D: begin
                // An ack in the same cycle as expiry wins over the timeout.
                if (mem_ack || tmr_expired_s) begin
                    state_d   = ARB_IDLE;
                    mem_req_d = 1'b0;
                    bus_err_d = !mem_ack;
                    if (state_q == ARB_GNT_IF) begin
                        if_ready_d = 1'b1;
                        if_rdata_d = mem_ack ? mem_rdata : {DATA_W{1'b0}};
                    end else begin
                        d_ready_d = 1'b1;
                        if (!mem_ack) begin
                            d_rdata_d = {DATA_W{1'b0}};
                        end else if (!mem_we_q) begin
                            d_rdata_d = mem_rdata;
                        end else begin
                            d_rdata_d = d_rdata_q;
                        end
                    end
                end else begin
                    tmr_en_s = 1'b1;
                end
            end
            default: begin
                state_d   = ARB_IDLE;
                mem_req_d = 1'b0;
            end
        endcase

        busy_d = (state_d != ARB_IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ARB_IDLE;
            last_d_q    <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= {ADDR_W{1'b0}};
            mem_wdata_q <= {DATA_W{1'b0}};
            if_ready_q  <= 1'b0;
            d_ready_q   <= 1'b0;
            if_rdata_q  <= {DATA_W{1'b0}};
            d_rdata_q   <= {DATA_W{1'b0}};
            bus_err_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_d_q    <= last_d_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_ready_q  <= if_ready_d;
            d_ready_q   <= d_ready_d;
            if_rdata_q  <= if_rdata_d;
            d_rdata_q   <= d_rdata_d;
            bus_err_q   <= bus_err_d;
            busy_q      <= busy_d;
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign if_ready  = if_ready_q;
    assign d_ready   = d_ready_q;
    assign if_rdata  = if_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign bus_err   = bus_err_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter (TIMEOUT = 4). Stimulus pushes the
// expected completion into a queue; a monitor pops and compares on every
// ready pulse. Inputs change on the falling edge, outputs are sampled there.
module tb_mem_port_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          if_req = 1'b0;
    logic [AW-1:0] if_addr = 32'h0;
    logic          if_ready;
    logic [DW-1:0] if_rdata;
    logic          d_req = 1'b0;
    logic          d_we = 1'b0;
    logic [AW-1:0] d_addr = 32'h0;
    logic [DW-1:0] d_wdata = 32'h0;
    logic          d_ready;
    logic [DW-1:0] d_rdata;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_ack;
    logic [DW-1:0] mem_rdata;
    logic          bus_err;
    logic          busy;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(4)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ready(d_ready), .d_rdata(d_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .bus_err(bus_err), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          is_d;
        logic [DW-1:0] rdata;
        logic          err;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // memory responder configuration
    logic          mem_auto = 1'b1;
    int            ack_delay = 0;   // -1: never acknowledge
    logic [DW-1:0] mem_model [logic [AW-1:0]];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic push_exp(input logic is_d, input logic [DW-1:0] rdata, input logic err);
        exp_t e;
        e.is_d = is_d; e.rdata = rdata; e.err = err;
        exp_q.push_back(e);
    endtask

    // Wait (bounded) for a ready pulse at a falling edge.
    task automatic wait_ready(input string nm, input int budget);
        bit seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (if_ready || d_ready) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: no ready within %0d cycles", nm, budget);
        end
    endtask

    // Count consecutive cycles with mem_req high; returns at the first low
    // cycle after the run.
    task automatic count_req(output int n);
        n = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (mem_req) n++;
            else if (n > 0) break;
        end
    endtask

    // Memory model: acks ack_delay cycles after mem_req rises.
    initial begin
        int wc = 0;
        mem_ack = 1'b0;
        mem_rdata = 32'h0;
        forever begin
            @(negedge clk);
            if (mem_auto) begin
                if (mem_req) begin
                    if (wc == ack_delay) begin
                        mem_ack = 1'b1;
                        mem_rdata = mem_model.exists(mem_addr) ? mem_model[mem_addr] : 32'h0;
                    end else begin
                        mem_ack = 1'b0;
                    end
                    wc++;
                end else begin
                    mem_ack = 1'b0;
                    wc = 0;
                end
            end
        end
    end

    // Monitor: every ready pulse must match the oldest expected completion.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (if_ready || d_ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_ready: got if_ready=%b d_ready=%b, expected none",
                             if_ready, d_ready);
                end else begin
                    e = exp_q.pop_front();
                    chk("ready_port", {30'h0, if_ready, d_ready}, e.is_d ? 32'h1 : 32'h2);
                    chk("rdata", e.is_d ? d_rdata : if_rdata, e.rdata);
                    chk("bus_err", {31'h0, bus_err}, {31'h0, e.err});
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        mem_model[32'h0000_0100] = 32'hE3A0_0001;
        mem_model[32'h0000_3000] = 32'h1234_5678;
        mem_model[32'h0000_0400] = 32'h1111_0400;
        mem_model[32'h0000_0500] = 32'h2222_0500;
        mem_model[32'h0000_0600] = 32'h3333_0600;

        // reset state
        repeat (2) @(negedge clk);
        chk("rst_mem_req", {31'h0, mem_req}, 32'h0);
        chk("rst_busy", {31'h0, busy}, 32'h0);
        chk("rst_ready", {30'h0, if_ready, d_ready}, 32'h0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_rdata", if_rdata | d_rdata, 32'h0);
        reset = 1'b0;

        // single fetch, ack in first mem_req cycle -> ready two edges after req
        @(negedge clk);
        if_req = 1'b1; if_addr = 32'h100; ack_delay = 0;
        push_exp(1'b0, 32'hE3A0_0001, 1'b0);
        @(negedge clk);
        chk("fetch_mem_req", {31'h0, mem_req}, 32'h1);
        chk("fetch_mem_addr", mem_addr, 32'h100);
        chk("fetch_mem_we", {31'h0, mem_we}, 32'h0);
        chk("fetch_busy", {31'h0, busy}, 32'h1);
        @(negedge clk);
        chk("fetch_latency", {31'h0, if_ready}, 32'h1);
        chk("fetch_mem_req_drop", {31'h0, mem_req}, 32'h0);
        if_req = 1'b0;

        // data read then write; write leaves d_rdata unchanged
        @(negedge clk);
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h3000; ack_delay = 0;
        push_exp(1'b1, 32'h1234_5678, 1'b0);
        wait_ready("d_read", 10);
        d_req = 1'b0;
        @(negedge clk);
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h2000; d_wdata = 32'hDEAD_BEEF; ack_delay = 3;
        push_exp(1'b1, 32'h1234_5678, 1'b0);
        @(negedge clk);
        chk("wr_mem_we", {31'h0, mem_we}, 32'h1);
        chk("wr_mem_addr", mem_addr, 32'h2000);
        chk("wr_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
        d_wdata = 32'h0;   // change mid-grant: must not disturb the transaction
        @(negedge clk);
        chk("wr_wdata_held", mem_wdata, 32'hDEAD_BEEF);
        wait_ready("d_write", 10);
        d_req = 1'b0; d_we = 1'b0;

        // contention from reset: D, IF, D, IF
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        if_req = 1'b1; if_addr = 32'h400;
        d_req = 1'b1; d_addr = 32'h500; ack_delay = 1;
        push_exp(1'b1, 32'h2222_0500, 1'b0);
        push_exp(1'b0, 32'h1111_0400, 1'b0);
        push_exp(1'b1, 32'h2222_0500, 1'b0);
        push_exp(1'b0, 32'h1111_0400, 1'b0);
        for (int k = 0; k < 4; k++) wait_ready("contention", 10);
        if_req = 1'b0; d_req = 1'b0;

        // timeout, no ack: mem_req high TIMEOUT+1 = 5 cycles
        @(negedge clk);
        d_req = 1'b1; d_addr = 32'h600; ack_delay = -1;
        push_exp(1'b1, 32'h0, 1'b1);
        count_req(n);
        chk("to_req_cycles", n, 32'd5);
        chk("to_ready_err", {30'h0, d_ready, bus_err}, 32'h3);
        d_req = 1'b0;

        // ack in the limit cycle wins
        @(negedge clk);
        d_req = 1'b1; ack_delay = 4;
        push_exp(1'b1, 32'h3333_0600, 1'b0);
        count_req(n);
        chk("ack_at_limit_cycles", n, 32'd5);
        chk("ack_at_limit_ready", {30'h0, d_ready, bus_err}, 32'h2);
        d_req = 1'b0;

        // reset mid-grant with a concurrent ack
        @(negedge clk);
        mem_auto = 1'b0; mem_ack = 1'b0;
        if_req = 1'b1; if_addr = 32'h100;
        @(negedge clk);
        chk("mid_mem_req", {31'h0, mem_req}, 32'h1);
        reset = 1'b1; mem_ack = 1'b1; mem_rdata = 32'h77;
        @(negedge clk);
        chk("mid_rst_req_busy", {30'h0, mem_req, busy}, 32'h0);
        chk("mid_rst_ready_err", {29'h0, if_ready, d_ready, bus_err}, 32'h0);
        chk("mid_rst_addr", mem_addr, 32'h0);
        chk("mid_rst_rdata", if_rdata, 32'h0);
        reset = 1'b0; mem_ack = 1'b0; if_req = 1'b0;
        @(negedge clk);
        mem_auto = 1'b1; ack_delay = 0;
        d_req = 1'b1; d_addr = 32'h500;
        push_exp(1'b1, 32'h2222_0500, 1'b0);
        wait_ready("post_reset", 10);
        d_req = 1'b0;

        // stray ack in IDLE
        @(negedge clk);
        mem_auto = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h55;
        repeat (2) @(negedge clk);
        chk("stray_ready", {29'h0, if_ready, d_ready, mem_req}, 32'h0);
        chk("stray_if_rdata", if_rdata, 32'h0);
        chk("stray_d_rdata", d_rdata, 32'h2222_0500);
        mem_ack = 1'b0;
        repeat (2) @(negedge clk);

        chk("scoreboard_empty", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
